fft_hw_hls_deadlock_report_ctrl: RTL and testbench

Central controller that sits downstream of the per-process deadlock detect units in the FFT_HW dataflow region. It collects every unit's `dl_detect_out` and confirms that a suspected deadlock persists. It then launches a report token from one origin process, traces the token around the dependence cycle, and generates `token_clear`. Finally it presents a latched report (origin process and cycle membership) to the debug/status interface with a valid/ack handshake.

---
 rtl/fft_hw_hls_deadlock_report_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_fft_hw_hls_deadlock_report_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_hw_hls_deadlock_report_ctrl.sv
// ----------------------------------------------------------------------------
// fft_hw_hls_deadlock_report_ctrl
//
// Central deadlock report controller for the FFT_HW dataflow region. It
// watches the per-process deadlock detect outputs and waits until a suspected
// deadlock has persisted for CONFIRM_CYCLES cycles. It then strobes one origin
// process and traces the report token around the dependence cycle. On closure
// it broadcasts token_clear and presents a latched report through a
// valid/ack handshake. After the report is consumed the controller locks
// until reset.
//
// Optional feature macro: FFT_HW_DL_TRACE_TIMEOUT_EN
//   defined   : TRACE aborts after TRACE_TIMEOUT cycles without closure and
//               counts the abort in false_alarm_cnt (saturating).
//   undefined : TRACE waits indefinitely; false_alarm_cnt is tied to 0.
//
// Ports
//   clock           in   sole clock, rising edge
//   reset           in   synchronous active-high reset
//   dl_detect_vec   in   [PROC_NUM]  dl_detect_out of each unit
//   token_seen_vec  in   [PROC_NUM]  OR of each unit's token_in_vec
//   origin_vec      out  [PROC_NUM]  one-hot origin strobe (ORIGIN only)
//   token_clear     out  broadcast clear, combinational in the closure cycle
//   dl_detect_flag  out  sticky "deadlock confirmed and traced"
//   report_vld      out  report valid
//   report_ack      in   report consumed
//   report_proc_id  out  [ID_W]      origin process index
//   report_path     out  [PROC_NUM]  processes whose token was seen
//   false_alarm_cnt out  [CNT_W]     aborted traces, saturating
// ----------------------------------------------------------------------------
module fft_hw_hls_deadlock_report_ctrl #(
   parameter int PROC_NUM       = 4,
   parameter int CONFIRM_CYCLES = 8,
   parameter int TRACE_TIMEOUT  = 256,
   parameter int CNT_W          = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [PROC_NUM-1:0] dl_detect_vec,
   input  logic [PROC_NUM-1:0] token_seen_vec,
   output logic [PROC_NUM-1:0] origin_vec,
   output logic                token_clear,
   output logic                dl_detect_flag,
   output logic                report_vld,
   input  logic                report_ack,
   output logic [((PROC_NUM > 1) ? $clog2(PROC_NUM) : 1)-1:0] report_proc_id,
   output logic [PROC_NUM-1:0] report_path,
   output logic [CNT_W-1:0]    false_alarm_cnt
);

   localparam int ID_W   = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
   // Largest count held is CONFIRM_CYCLES-1, which always fits here.
   localparam int CONF_W = $clog2(CONFIRM_CYCLES);

   // Parameter legality checks, evaluated at elaboration only.
   if (CONFIRM_CYCLES < 2) begin : g_bad_confirm
      $error("CONFIRM_CYCLES must be >= 2");
   end
   if (TRACE_TIMEOUT < 1) begin : g_bad_timeout
      $error("TRACE_TIMEOUT must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONFIRM,
      S_ORIGIN,
      S_TRACE,
      S_REPORT,
      S_LOCKED
   } state_t;

   state_t              state_q, state_d;
   logic [CONF_W-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]     origin_id_q, origin_id_d;
   logic [ID_W-1:0]     proc_id_q, proc_id_d;
   logic [PROC_NUM-1:0] path_q, path_d;
   logic                flag_q, flag_d;
   logic [ID_W-1:0]     low_id;
   logic                closure;

   // Index of the lowest set bit; scanning downward lets the lowest win.
   always_comb begin
      low_id = '0;
      for (int p = PROC_NUM - 1; p >= 0; p--) begin
         if (dl_detect_vec[p]) low_id = ID_W'(p);
      end
   end

   // The token has come back to the origin while the origin still reports
   // itself blocked: the dependence cycle is closed.
   assign closure = token_seen_vec[origin_id_q] & dl_detect_vec[origin_id_q];

`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TRACE_TIMEOUT + 1);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] fa_q, fa_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      origin_id_d = origin_id_q;
      proc_id_d   = proc_id_q;
      path_d      = path_q;
      flag_d      = flag_q;
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
      timer_d     = timer_q;
      fa_d        = fa_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|dl_detect_vec) begin
               state_d = S_CONFIRM;
               cnt_d   = CONF_W'(1);
            end
         end
         S_CONFIRM: begin
            if (dl_detect_vec == '0) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CONF_W'(CONFIRM_CYCLES - 1)) begin
               state_d     = S_ORIGIN;
               origin_id_d = low_id;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ORIGIN: begin
            path_d  = '0;
            state_d = S_TRACE;
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
            timer_d = '0;
`endif
         end
         S_TRACE: begin
            path_d = path_q | token_seen_vec;
            // Closure is tested first so that it wins over a coincident timeout.
            if (closure) begin
               state_d   = S_REPORT;
               flag_d    = 1'b1;
               proc_id_d = origin_id_q;
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
            end else if (timer_q == TMR_W'(TRACE_TIMEOUT - 1)) begin
               state_d = S_IDLE;
               path_d  = '0;
               timer_d = '0;
               if (fa_q != '1) fa_d = fa_q + 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
`endif
            end
         end
         S_REPORT: begin
            if (report_ack) state_d = S_LOCKED;
         end
         S_LOCKED: begin
            state_d = S_LOCKED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         origin_id_q <= '0;
         proc_id_q   <= '0;
         path_q      <= '0;
         flag_q      <= 1'b0;
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
         timer_q     <= '0;
         fa_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         origin_id_q <= origin_id_d;
         proc_id_q   <= proc_id_d;
         path_q      <= path_d;
         flag_q      <= flag_d;
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
         timer_q     <= timer_d;
         fa_q        <= fa_d;
`endif
      end
   end

   assign origin_vec     = (state_q == S_ORIGIN) ? (PROC_NUM'(1) << origin_id_q) : '0;
   // A reset landing in the closure cycle must not broadcast a clear.
   assign token_clear    = (state_q == S_TRACE) & closure & ~reset;
   assign report_vld     = (state_q == S_REPORT);
   assign dl_detect_flag = flag_q;
   assign report_proc_id = proc_id_q;
   assign report_path    = path_q;
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
   assign false_alarm_cnt = fa_q;
`else
   assign false_alarm_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_hw_hls_deadlock_report_ctrl.sv
// ----------------------------------------------------------------------------
// Directed testbench for fft_hw_hls_deadlock_report_ctrl (PROC_NUM=4,
// CONFIRM_CYCLES=8, TRACE_TIMEOUT=16). Inputs are driven 1 time unit after
// the rising edge and outputs are sampled 1 time unit later, so every value
// observed after step() belongs to the current cycle. The timeout scenario is
// built only when FFT_HW_DL_TRACE_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_fft_hw_hls_deadlock_report_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] dl_detect_vec = '0;
   logic [3:0] token_seen_vec = '0;
   logic [3:0] origin_vec;
   logic       token_clear;
   logic       dl_detect_flag;
   logic       report_vld;
   logic       report_ack = 1'b0;
   logic [1:0] report_proc_id;
   logic [3:0] report_path;
   logic [7:0] false_alarm_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   fft_hw_hls_deadlock_report_ctrl #(
      .PROC_NUM(4), .CONFIRM_CYCLES(8), .TRACE_TIMEOUT(16), .CNT_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .dl_detect_vec(dl_detect_vec),
      .token_seen_vec(token_seen_vec),
      .origin_vec(origin_vec),
      .token_clear(token_clear),
      .dl_detect_flag(dl_detect_flag),
      .report_vld(report_vld),
      .report_ack(report_ack),
      .report_proc_id(report_proc_id),
      .report_path(report_path),
      .false_alarm_cnt(false_alarm_cnt)
   );

   // Advance one cycle and apply this cycle's inputs.
   task automatic step(input logic [3:0] dl, input logic [3:0] tok,
                       input logic ack, input logic rst);
      @(posedge clock);
      #1;
      dl_detect_vec  = dl;
      token_seen_vec = tok;
      report_ack     = ack;
      reset          = rst;
      #1;
   endtask

   task automatic test_reset;
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      total++;
      if ({origin_vec, token_clear, dl_detect_flag, report_vld, report_proc_id, report_path} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=0", {origin_vec, token_clear, dl_detect_flag, report_vld, report_proc_id, report_path});
      end
      total++;
      if (false_alarm_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_fa got=%0d exp=0", false_alarm_cnt);
      end
      $display("test_reset done");
   endtask

   task automatic test_confirm;
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(4'b0110, 4'b0000, 1'b0, 1'b0);
         total++;
         if (origin_vec !== 4'b0000) begin
            bad++;
            $display("FAIL confirm_early_origin cyc=%0d got=%b exp=0000", i, origin_vec);
         end
      end
      step(4'b0110, 4'b0000, 1'b0, 1'b0);
      total++;
      if (origin_vec !== 4'b0010) begin
         bad++;
         $display("FAIL confirm_origin got=%b exp=0010", origin_vec);
      end
      step(4'b0110, 4'b0000, 1'b0, 1'b0);
      total++;
      if (origin_vec !== 4'b0000) begin
         bad++;
         $display("FAIL confirm_origin_one_cycle got=%b exp=0000", origin_vec);
      end
      $display("test_confirm done");
   endtask

   task automatic test_glitch;
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(4'b1010, 4'b0000, 1'b0, 1'b0);
         total++;
         if (origin_vec !== 4'b0000) begin
            bad++;
            $display("FAIL glitch_origin cyc=%0d got=%b exp=0000", i, origin_vec);
         end
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(4'b1000, 4'b0000, 1'b0, 1'b0);
         total++;
         if (origin_vec !== 4'b0000) begin
            bad++;
            $display("FAIL glitch_rerun_early cyc=%0d got=%b exp=0000", i, origin_vec);
         end
      end
      step(4'b1000, 4'b0000, 1'b0, 1'b0);
      total++;
      if (origin_vec !== 4'b1000) begin
         bad++;
         $display("FAIL glitch_rerun_origin got=%b exp=1000", origin_vec);
      end
      $display("test_glitch done");
   endtask

   task automatic test_full_trace;
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(4'b0010, 4'b0000, 1'b0, 1'b0);
      step(4'b0010, 4'b0000, 1'b0, 1'b0);
      total++;
      if (origin_vec !== 4'b0010) begin
         bad++;
         $display("FAIL trace_origin got=%b exp=0010", origin_vec);
      end
      step(4'b0010, 4'b0100, 1'b0, 1'b0);
      total++;
      if (token_clear !== 1'b0) begin
         bad++;
         $display("FAIL trace_tc_bit2 got=%b exp=0", token_clear);
      end
      step(4'b0010, 4'b1000, 1'b0, 1'b0);
      total++;
      if (token_clear !== 1'b0) begin
         bad++;
         $display("FAIL trace_tc_bit3 got=%b exp=0", token_clear);
      end
      step(4'b0010, 4'b0010, 1'b0, 1'b0);
      total++;
      if ({token_clear, report_vld} !== 2'b10) begin
         bad++;
         $display("FAIL trace_closure tc_vld got=%b exp=10", {token_clear, report_vld});
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      total++;
      if ({token_clear, report_vld, dl_detect_flag} !== 3'b011) begin
         bad++;
         $display("FAIL trace_report tc_vld_flag got=%b exp=011", {token_clear, report_vld, dl_detect_flag});
      end
      total++;
      if (report_proc_id !== 2'd1) begin
         bad++;
         $display("FAIL trace_proc_id got=%0d exp=1", report_proc_id);
      end
      total++;
      if (report_path !== 4'b1110) begin
         bad++;
         $display("FAIL trace_path got=%b exp=1110", report_path);
      end
      total++;
      if (false_alarm_cnt !== 8'd0) begin
         bad++;
         $display("FAIL trace_fa got=%0d exp=0", false_alarm_cnt);
      end
      $display("test_full_trace done");
   endtask

   // Continues from the REPORT state left by test_full_trace.
   task automatic test_handshake;
      for (int i = 0; i < 10; i++) begin
         step(4'b0000, 4'b0000, 1'b0, 1'b0);
         total++;
         if ({report_vld, report_proc_id, report_path} !== 7'b1_01_1110) begin
            bad++;
            $display("FAIL hs_hold cyc=%0d got=%b exp=1011110", i, {report_vld, report_proc_id, report_path});
         end
      end
      step(4'b0000, 4'b0000, 1'b1, 1'b0);
      total++;
      if (report_vld !== 1'b1) begin
         bad++;
         $display("FAIL hs_ack_cycle_vld got=%b exp=1", report_vld);
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      total++;
      if ({report_vld, dl_detect_flag, report_proc_id, report_path} !== 8'b0_1_01_1110) begin
         bad++;
         $display("FAIL hs_locked got=%b exp=01011110", {report_vld, dl_detect_flag, report_proc_id, report_path});
      end
      for (int i = 0; i < 12; i++) begin
         step(4'b1111, 4'b1111, 1'b1, 1'b0);
         total++;
         if ({origin_vec, token_clear, report_vld, dl_detect_flag} !== 7'b0000_0_0_1) begin
            bad++;
            $display("FAIL hs_locked_ignore cyc=%0d got=%b exp=0000001", i, {origin_vec, token_clear, report_vld, dl_detect_flag});
         end
      end
      $display("test_handshake done");
   endtask

   task automatic test_reset_mid_trace;
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(4'b0001, 4'b0000, 1'b0, 1'b0);
      step(4'b0001, 4'b0000, 1'b0, 1'b0);
      total++;
      if (origin_vec !== 4'b0001) begin
         bad++;
         $display("FAIL rmt_origin got=%b exp=0001", origin_vec);
      end
      step(4'b0001, 4'b0100, 1'b0, 1'b0);
      // Closure inputs presented while reset is high: no clear allowed.
      step(4'b0001, 4'b0001, 1'b0, 1'b1);
      total++;
      if (token_clear !== 1'b0) begin
         bad++;
         $display("FAIL rmt_tc_in_reset got=%b exp=0", token_clear);
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      total++;
      if ({origin_vec, token_clear, dl_detect_flag, report_vld, report_proc_id, report_path, false_alarm_cnt} !== 21'd0) begin
         bad++;
         $display("FAIL rmt_outputs got=%b exp=0", {origin_vec, token_clear, dl_detect_flag, report_vld, report_proc_id, report_path, false_alarm_cnt});
      end
      for (int i = 0; i < 8; i++) step(4'b0100, 4'b0000, 1'b0, 1'b0);
      step(4'b0100, 4'b0000, 1'b0, 1'b0);
      total++;
      if (origin_vec !== 4'b0100) begin
         bad++;
         $display("FAIL rmt_reconfirm got=%b exp=0100", origin_vec);
      end
      $display("test_reset_mid_trace done");
   endtask

`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
   task automatic test_timeout;
      step(4'b0000, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) step(4'b0001, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(4'b0001, 4'b0100, 1'b0, 1'b0);
         total++;
         if ({token_clear, report_vld} !== 2'b00) begin
            bad++;
            $display("FAIL to_trace cyc=%0d got=%b exp=00", i, {token_clear, report_vld});
         end
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      total++;
      if ({false_alarm_cnt, report_path, report_vld} !== 13'b00000001_0000_0) begin
         bad++;
         $display("FAIL to_abort fa_path_vld got=%b exp=0000000100000", {false_alarm_cnt, report_path, report_vld});
      end
      for (int i = 0; i < 9; i++) step(4'b0001, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) step(4'b0001, 4'b0100, 1'b0, 1'b0);
      step(4'b0001, 4'b0001, 1'b0, 1'b0);
      total++;
      if (token_clear !== 1'b1) begin
         bad++;
         $display("FAIL to_closure_wins_tc got=%b exp=1", token_clear);
      end
      step(4'b0000, 4'b0000, 1'b0, 1'b0);
      total++;
      if ({report_vld, false_alarm_cnt} !== 9'b1_00000001) begin
         bad++;
         $display("FAIL to_closure_wins got=%b exp=100000001", {report_vld, false_alarm_cnt});
      end
      $display("test_timeout done");
   endtask
`endif

   initial begin
      test_reset();
      test_confirm();
      test_glitch();
      test_full_trace();
      test_handshake();
      test_reset_mid_trace();
`ifdef FFT_HW_DL_TRACE_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
